xbar_arbiter: RTL
=================

Name: xbar_arbiter

Overview:
- Sequences the 3x3 switch datapath: input-port packet RAMs, 4:1 output muxes and output FIFOs.
- Each input presents one pending packet: destination port, base address and length.
- One engine per output port picks among contending inputs round-robin, streams the words out of the winner's RAM through the output mux into the output FIFO, then acknowledges the input.
- Replaces ad-hoc enable juggling in the top level with a single owner of the RAM read ports, mux selects and FIFO writes.

Parameters:
- N_PORTS, 3: number of input and output ports.
- ADDR_W, 12: input RAM address width.
- LEN_W, 8: packet length field width, in 32-bit words.
- SEL_W, 2: mux select width. Code 0 = idle source; code i+1 = input i.
- RD_LAT, 1: input RAM read latency, rden to valid q.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_PORTS  input i has a packet pending; held until req_ack[i]
- req_dest  in  N_PORTS*SEL_W  per-input destination output index (0..N_PORTS-1)
- req_base  in  N_PORTS*ADDR_W  per-input packet start address
- req_len  in  N_PORTS*LEN_W  per-input packet length in words
- req_ack  out  N_PORTS  one-cycle pulse when input i's packet is fully written
- ram_rden  out  N_PORTS  input RAM read enable
- ram_rd_add  out  N_PORTS*ADDR_W  input RAM read address
- mux_sel  out  N_PORTS*SEL_W  per-output mux select
- fifo_wr  out  N_PORTS  output FIFO write request
- fifo_afull  in  N_PORTS  output FIFO free space <= RD_LAT words
- busy  out  N_PORTS  output engine not IDLE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset:
  - All outputs 0; all engines IDLE; rr_ptr[o] = 0; read pipelines cleared.
  - Reset mid-transfer aborts the transfer: no req_ack, no further fifo_wr.
- Per-output FSM, states IDLE -> XFER -> DRAIN -> IDLE.
- IDLE:
  - Candidates: inputs i with req_valid[i], req_dest[i]==o, and i not owned.
  - Search order starts at rr_ptr[o], incrementing mod N_PORTS; first candidate wins.
  - Capture base, len and owner. Next state XFER, or DRAIN if len==0.
  - req_dest >= N_PORTS: request is never granted; no error response.
- XFER, each cycle with fifo_afull[o]==0:
  - ram_rden[owner]=1, ram_rd_add[owner] = base+cnt (mod 2^ADDR_W, wraps silently), cnt++.
  - After issuing read len-1, next state DRAIN.
  - While fifo_afull[o]==1: no read issued, cnt held; the stall is unbounded.
- Write path: fifo_wr[o] asserts exactly RD_LAT cycles after each issued read, once per word, in order, via a RD_LAT-deep valid shift register.
- DRAIN:
  - Wait until the valid pipeline is empty.
  - Then pulse req_ack[owner] for 1 cycle, set rr_ptr[o] = (owner+1) mod N_PORTS, go IDLE.
- mux_sel[o] = owner+1 during XFER and DRAIN, 0 otherwise.
- Ownership: an input belongs to at most one output because each input has a single req_dest. Per-input RAM outputs are the OR of all engines' contributions.
- req_base, req_len and req_dest changes after grant are ignored. A req_valid drop after grant is ignored and the transfer completes.
- Latency, len=L, no stalls:
  - Grant in cycle 0.
  - rden in cycles 1..L.
  - fifo_wr in cycles 1+RD_LAT..L+RD_LAT.
  - req_ack in cycle L+RD_LAT+1.
  - Next grant to the same output is evaluated in the cycle after req_ack.
- The earliest a re-request from the acked input is seen is the cycle after req_ack, since req_valid must still be high in the ack cycle.

Optional Feature:
- Macro XBAR_STATS_EN.
- Defined: adds output pkt_cnt (N_PORTS*16), a per-output wrapping count of req_ack pulses, and output stall_cnt (N_PORTS*16), a per-output wrapping count of XFER cycles with fifo_afull high. Both clear on reset.
- Undefined: both ports exist but are tied to 0; no counter logic.

Decomposition:
- Package switch_pkg:
  - N_PORTS, SEL_W, ADDR_W, LEN_W.
  - SEL_IDLE = 0.
  - Enum xbar_state_t {IDLE, XFER, DRAIN}.
  - Function sel_of(input index).
- Sub-module xbar_out_engine: one output's FSM, round-robin pointer, counter and valid pipeline.
  - Instantiated N_PORTS times in a generate loop.
- Top level: request decode per output, OR-merge of RAM outputs, stats.

Test Plan:
- Single packet: input 0, dest 2, base 0x010, len 4 -> rden0 cycles 1-4, addresses 0x010-0x013; mux_sel[2]=1; fifo_wr[2] cycles 2-5; req_ack[0] in cycle 6.
- Contention: inputs 0,1,2 all dest 0, len 2 -> service order 0,1,2 then 0 again; exactly 2 fifo_wr per grant.
- Parallel: input 0->1 and input 1->0, len 3, same cycle -> both transfers overlap cycle-for-cycle; no cross-talk on ram_rd_add.
- Backpressure: len 5, fifo_afull high for cycles 2-4 -> no rden in cycles 2-4; exactly 5 fifo_wr total; ack delayed 3 cycles.
- Boundaries:
  - base 0xFFE, len 4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
  - len 0 -> req_ack at cycle 2, with no rden and no fifo_wr.
- Reset in cycle 3 of a len-8 transfer -> all outputs 0 next cycle; no ack; re-request after reset restarts at base.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared sizing, FSM state type and index helpers for the 3x3 switch sequencer.
package switch_pkg;
  localparam int N_PORTS = 3;
  localparam int SEL_W   = 2;
  localparam int ADDR_W  = 12;
  localparam int LEN_W   = 8;
  localparam int RD_LAT  = 1;
  localparam int IDX_W   = $clog2(N_PORTS);

  localparam logic [SEL_W-1:0] SEL_IDLE = 2'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } xbar_state_t;

  function automatic logic [SEL_W-1:0] sel_of(input logic [IDX_W-1:0] idx);
    return SEL_W'(idx) + SEL_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(N_PORTS - 1)) begin
      return {IDX_W{1'b0}};
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction
endpackage

// File: rtl/xbar_out_engine.sv
// One output port: round-robin grant, read sequencing out of the owner's RAM and
// the read-latency valid pipeline that drives the output FIFO write.
module xbar_out_engine
  import switch_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORTS-1:0]        i_cand,
  input  logic [N_PORTS*ADDR_W-1:0] i_base,
  input  logic [N_PORTS*LEN_W-1:0]  i_len,
  input  logic                      i_afull,
  output logic                      o_rden,
  output logic [ADDR_W-1:0]         o_rd_add,
  output logic [N_PORTS-1:0]        o_own,
  output logic                      o_ack,
  output logic [SEL_W-1:0]          o_mux_sel,
  output logic                      o_fifo_wr,
  output logic                      o_busy
`ifdef XBAR_STATS_EN
  ,
  output logic                      o_stall
`endif
);
  localparam int DW = $clog2(RD_LAT + 1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  xbar_state_t       r_state, w_next;
  logic [IDX_W-1:0]  r_rr, r_owner, w_pick;
  logic              w_found, w_issue;
  logic [ADDR_W-1:0] r_base, w_pick_base;
  logic [LEN_W-1:0]  r_len, r_cnt, w_pick_len;
  logic [RD_LAT-1:0] r_vld;
  logic [DW-1:0]     r_wait;

  // Round-robin search from r_rr; the first pending candidate wins.
  always_comb begin
    w_found     = 1'b0;
    w_pick      = r_rr;
    w_pick_base = {ADDR_W{1'b0}};
    w_pick_len  = {LEN_W{1'b0}};
    for (int k = 0; k < N_PORTS; k++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (!w_found && i_cand[i] && (((int'(r_rr) + k) % N_PORTS) == i)) begin
          w_found     = 1'b1;
          w_pick      = IDX_W'(i);
          w_pick_base = i_base[i*ADDR_W +: ADDR_W];
          w_pick_len  = i_len[i*LEN_W +: LEN_W];
        end else begin
          w_found = w_found;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, read issue and acknowledge.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    o_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_next = (w_pick_len == {LEN_W{1'b0}}) ? DRAIN : XFER;
        end else begin
          w_next = IDLE;
        end
      end
      XFER: begin
        if (!i_afull) begin
          w_issue = 1'b1;
          if ((r_cnt + LEN_ONE) == r_len) begin
            w_next = DRAIN;
          end else begin
            w_next = XFER;
          end
        end else begin
          w_next = XFER;
        end
      end
      DRAIN: begin
        // r_wait covers the RD_LAT cycles after the last read, even for len 0.
        if ((r_wait == {DW{1'b0}}) && (r_vld == {RD_LAT{1'b0}})) begin
          o_ack  = 1'b1;
          w_next = IDLE;
        end else begin
          w_next = DRAIN;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Transfer bookkeeping, round-robin pointer and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr    <= {IDX_W{1'b0}};
      r_owner <= {IDX_W{1'b0}};
      r_base  <= {ADDR_W{1'b0}};
      r_len   <= {LEN_W{1'b0}};
      r_cnt   <= {LEN_W{1'b0}};
      r_vld   <= {RD_LAT{1'b0}};
      r_wait  <= {DW{1'b0}};
    end else begin
      r_vld[0] <= w_issue;
      for (int j = 1; j < RD_LAT; j++) begin
        r_vld[j] <= r_vld[j-1];
      end
      if ((r_state == IDLE) && w_found) begin
        r_owner <= w_pick;
        r_base  <= w_pick_base;
        r_len   <= w_pick_len;
        r_cnt   <= {LEN_W{1'b0}};
      end else if (w_issue) begin
        r_cnt <= r_cnt + LEN_ONE;
      end
      if ((w_next == DRAIN) && (r_state != DRAIN)) begin
        r_wait <= DW'(RD_LAT);
      end else if (r_wait != {DW{1'b0}}) begin
        r_wait <= r_wait - DW'(1);
      end
      if (o_ack) begin
        r_rr <= idx_inc(r_owner);
      end
    end
  end

  // Outputs, gated to zero whenever this engine holds no grant.
  always_comb begin
    o_busy    = (r_state != IDLE);
    o_rden    = w_issue;
    o_rd_add  = w_issue ? (r_base + ADDR_W'(r_cnt)) : {ADDR_W{1'b0}};
    o_mux_sel = o_busy ? sel_of(r_owner) : SEL_IDLE;
    o_fifo_wr = r_vld[RD_LAT-1];
    o_own     = {N_PORTS{1'b0}};
    for (int i = 0; i < N_PORTS; i++) begin
      o_own[i] = o_busy && (r_owner == IDX_W'(i));
    end
  end

`ifdef XBAR_STATS_EN
  assign o_stall = (r_state == XFER) && i_afull;
`endif
endmodule

// File: rtl/xbar_arbiter.sv
// 3x3 switch sequencer: per-output engines, request decode and RAM-port merge.
// Define XBAR_STATS_EN for per-output packet/stall counters (tied to 0 otherwise).
module xbar_arbiter
  import switch_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORTS-1:0]        req_valid,
  input  logic [N_PORTS*SEL_W-1:0]  req_dest,
  input  logic [N_PORTS*ADDR_W-1:0] req_base,
  input  logic [N_PORTS*LEN_W-1:0]  req_len,
  output logic [N_PORTS-1:0]        req_ack,
  output logic [N_PORTS-1:0]        ram_rden,
  output logic [N_PORTS*ADDR_W-1:0] ram_rd_add,
  output logic [N_PORTS*SEL_W-1:0]  mux_sel,
  output logic [N_PORTS-1:0]        fifo_wr,
  input  logic [N_PORTS-1:0]        fifo_afull,
  output logic [N_PORTS-1:0]        busy,
  output logic [N_PORTS*16-1:0]     pkt_cnt,
  output logic [N_PORTS*16-1:0]     stall_cnt
);
  logic [N_PORTS-1:0][N_PORTS-1:0] w_cand, w_own;
  logic [N_PORTS-1:0]              w_owned, w_rden, w_ack;
  logic [N_PORTS-1:0][ADDR_W-1:0]  w_add;
`ifdef XBAR_STATS_EN
  logic [N_PORTS-1:0]              w_stall;
`endif

  // Candidates per output: pending, addressed here, and not already being served.
  always_comb begin
    w_owned = {N_PORTS{1'b0}};
    for (int o = 0; o < N_PORTS; o++) begin
      w_owned = w_owned | w_own[o];
    end
    for (int o = 0; o < N_PORTS; o++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        w_cand[o][i] = req_valid[i] && (req_dest[i*SEL_W +: SEL_W] == SEL_W'(o)) && !w_owned[i];
      end
    end
  end

  // OR-merge each engine's read port and ack onto the input it owns.
  always_comb begin
    ram_rden   = {N_PORTS{1'b0}};
    ram_rd_add = {(N_PORTS*ADDR_W){1'b0}};
    req_ack    = {N_PORTS{1'b0}};
    for (int i = 0; i < N_PORTS; i++) begin
      for (int o = 0; o < N_PORTS; o++) begin
        ram_rden[i] = ram_rden[i] | (w_rden[o] & w_own[o][i]);
        ram_rd_add[i*ADDR_W +: ADDR_W] = ram_rd_add[i*ADDR_W +: ADDR_W] |
                                         (w_add[o] & {ADDR_W{w_own[o][i]}});
        req_ack[i] = req_ack[i] | (w_ack[o] & w_own[o][i]);
      end
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_eng
    xbar_out_engine u_eng (
      .clk       (clk),
      .reset     (reset),
      .i_cand    (w_cand[g]),
      .i_base    (req_base),
      .i_len     (req_len),
      .i_afull   (fifo_afull[g]),
      .o_rden    (w_rden[g]),
      .o_rd_add  (w_add[g]),
      .o_own     (w_own[g]),
      .o_ack     (w_ack[g]),
      .o_mux_sel (mux_sel[g*SEL_W +: SEL_W]),
      .o_fifo_wr (fifo_wr[g]),
      .o_busy    (busy[g])
`ifdef XBAR_STATS_EN
      ,
      .o_stall   (w_stall[g])
`endif
    );
  end

`ifdef XBAR_STATS_EN
  logic [N_PORTS-1:0][15:0] r_pkt, r_stall;

  // Per-output wrapping packet and stall counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt   <= {(N_PORTS*16){1'b0}};
      r_stall <= {(N_PORTS*16){1'b0}};
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (w_ack[o]) begin
          r_pkt[o] <= r_pkt[o] + 16'd1;
        end
        if (w_stall[o]) begin
          r_stall[o] <= r_stall[o] + 16'd1;
        end
      end
    end
  end

  assign pkt_cnt   = r_pkt;
  assign stall_cnt = r_stall;
`else
  assign pkt_cnt   = {(N_PORTS*16){1'b0}};
  assign stall_cnt = {(N_PORTS*16){1'b0}};
`endif
endmodule
